vec_stream_fifo: RTL

Parametrised synchronous FIFO for the vector accelerator datapath, replacing the fixed 8-bit FIFO.
- Generic data width and depth.
- Exact occupancy count and programmable almost-full/almost-empty flags.
- Sticky overflow/underflow error flags.
- Synchronous flush.
- Sits between the host-interface word stream and the vector lanes.

---
 rtl/vec_fifo_pkg.sv | 24 ++
 rtl/vec_stream_fifo_ram.sv | 23 ++
 rtl/vec_stream_fifo.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/vec_fifo_pkg.sv
// Shared constants, helpers and CSR status-bit layout for the vector stream FIFO.
package vec_fifo_pkg;

  localparam int VEC_DATA_WIDTH = 32;
  localparam int VEC_DEPTH_LOG  = 4;

  // Address width for a storage array of 'depth' entries; never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  // Bit positions of the FIFO flags inside the CSR status word.
  typedef enum int unsigned {
    STAT_EMPTY        = 0,
    STAT_FULL         = 1,
    STAT_ALMOST_EMPTY = 2,
    STAT_ALMOST_FULL  = 3,
    STAT_UNDERFLOW    = 4,
    STAT_OVERFLOW     = 5
  } status_bit_e;

  localparam int STATUS_W = 6;

endpackage

// File: rtl/vec_stream_fifo_ram.sv
// fifo_ram: simple dual-port storage, synchronous write port and asynchronous read port.
module fifo_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_W     = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_W];

  // NOTE: storage has no reset; occupancy lives in the pointers, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/vec_stream_fifo.sv
// Parametrised synchronous FIFO between the host word stream and the vector lanes.
// Define VEC_FIFO_FWFT_EN for first-word-fall-through reads; otherwise reads have 1-cycle latency.
module vec_stream_fifo
  import vec_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = VEC_DATA_WIDTH,
  parameter int DEPTH_LOG  = VEC_DEPTH_LOG,
  parameter int AF_LEVEL   = (2 ** DEPTH_LOG) - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [DEPTH_LOG:0]    count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  localparam int DEPTH = 2 ** DEPTH_LOG;
  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = DEPTH_LOG + 1;

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_LEVEL);

  if (AF_LEVEL > DEPTH || AE_LEVEL >= DEPTH) begin : g_bad_levels
    $error("vec_stream_fifo: AF_LEVEL must be <= DEPTH and AE_LEVEL must be < DEPTH");
  end

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Flags decode the registered count directly so they track it in the same cycle.
  assign count        = count_q;
  assign full         = (count_q == DEPTH_CNT);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_CNT);
  assign almost_empty = (count_q <= AE_CNT);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign wr_acc = wr_en & ~full  & ~flush;
  assign rd_acc = rd_en & ~empty & ~flush;

  // NOTE: every always_comb output is given a default first so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Error flags are sticky; a new error in the clearing cycle takes precedence.
  always_comb begin
    overflow_d  = (overflow_q  & ~err_clr) | (wr_en & full  & ~flush);
    underflow_d = (underflow_q & ~err_clr) | (rd_en & empty & ~flush);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (PTR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_q),
    .rd_data (ram_rdata)
  );

`ifdef VEC_FIFO_FWFT_EN
  // Head entry is shown while non-empty; zero otherwise so reset presents rd_data=0.
  assign rd_data  = empty ? '0 : ram_rdata;
  assign rd_valid = ~empty;
`else
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;

  always_comb begin
    rd_data_d  = rd_acc ? ram_rdata : rd_data_q;
    rd_valid_d = rd_acc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

endmodule
